// File: rtl/bcd_to_binary_converter.sv
// -----------------------------------------------------------------------------
// bcd_to_binary_converter
//
// Sequential packed-BCD to unsigned binary converter using reverse double
// dabble. Each conversion iteration shifts {bcd_sr, bin_sr} right by one bit,
// then subtracts 3 from every BCD digit that became >= 8. After BIN_WIDTH
// iterations bin_sr holds the binary value. Words with any digit > 9 are not
// converted: they go straight to DONE with error set and a zero result.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. in_ready is high only in IDLE;
// out_valid is high only in DONE. A result is held until out_ready is seen.
//
// Ports:
//   clk           - clock, rising edge
//   rst           - asynchronous active-high reset
//   in_valid      - bcd_input holds a word to convert
//   in_ready      - block can accept a word (IDLE)
//   bcd_input     - packed BCD, digit 0 in bits [3:0]
//   out_valid     - binary_output / error are valid (DONE)
//   out_ready     - downstream takes the result
//   binary_output - converted value, 0 when error is set
//   error         - accepted word had a digit greater than 9
//   dbg_state     - current FSM state (0=IDLE, 1=CONVERT, 2=DONE)
// -----------------------------------------------------------------------------
module bcd_to_binary_converter #(
    parameter int DIGITS    = 3,
    parameter int BIN_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_input,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_WIDTH-1:0]  binary_output,
    output logic                  error,
    output logic [1:0]            dbg_state
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [BCD_W-1:0]     bcd_sr_q, bcd_sr_d;
    logic [BIN_WIDTH-1:0] bin_sr_q, bin_sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0] result_q, result_d;
    logic                 error_q, error_d;

    // One iteration of the datapath, computed combinationally from the
    // current shift registers.
    logic [BCD_W+BIN_WIDTH-1:0] shifted;
    logic [BCD_W-1:0]           sh_bcd;
    logic [BIN_WIDTH-1:0]       sh_bin;
    logic [BCD_W-1:0]           corr_bcd;
    logic                       input_bad;

    always_comb begin
        shifted  = {bcd_sr_q, bin_sr_q} >> 1;
        sh_bcd   = shifted[BCD_W+BIN_WIDTH-1:BIN_WIDTH];
        sh_bin   = shifted[BIN_WIDTH-1:0];
        corr_bcd = sh_bcd;
        // Digit corrections are independent of each other: a digit >= 8
        // after the shift came from a digit >= 16 in "halved" weight terms,
        // so remove the 6/2 = 3 excess.
        for (int i = 0; i < DIGITS; i++) begin
            if (sh_bcd[4*i +: 4] >= 4'd8) begin
                corr_bcd[4*i +: 4] = sh_bcd[4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        input_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_input[4*i +: 4] > 4'd9) begin
                input_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        bcd_sr_d = bcd_sr_q;
        bin_sr_d = bin_sr_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        error_d  = error_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (input_bad) begin
                        result_d = '0;
                        error_d  = 1'b1;
                        state_d  = DONE;
                    end else begin
                        bcd_sr_d = bcd_input;
                        bin_sr_d = '0;
                        cnt_d    = '0;
                        state_d  = CONVERT;
                    end
                end
            end
            CONVERT: begin
                bcd_sr_d = corr_bcd;
                bin_sr_d = sh_bin;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    result_d = sh_bin;
                    error_d  = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bcd_sr_q <= '0;
            bin_sr_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcd_sr_q <= bcd_sr_d;
            bin_sr_q <= bin_sr_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == DONE);
    assign binary_output = result_q;
    assign error         = error_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_binary_converter
//
// Directed and randomized checks of bcd_to_binary_converter against a
// decimal reference model (digit-by-digit value = value*10 + digit).
// -----------------------------------------------------------------------------
module tb_bcd_to_binary_converter;

  localparam int DIGITS    = 3;
  localparam int BIN_WIDTH = 10;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [4*DIGITS-1:0]  bcd_input;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIN_WIDTH-1:0] binary_output;
  logic                 error;
  logic [1:0]           dbg_state;

  int total = 0;
  int bad   = 0;

  bcd_to_binary_converter #(
    .DIGITS   (DIGITS),
    .BIN_WIDTH(BIN_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .bcd_input    (bcd_input),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .binary_output(binary_output),
    .error        (error),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal value of the packed digits, zero with error if any
  // digit is not decimal.
  function automatic void ref_conv(input logic [4*DIGITS-1:0] w, output logic err, output int val);
    logic [3:0] d;
    err = 1'b0;
    val = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = w[4*i +: 4];
      if (d > 4'd9) err = 1'b1;
      val = val * 10 + int'(d);
    end
    if (err) val = 0;
  endfunction

  // driver: present one word and let it be taken on the next rising edge
  task automatic accept(input logic [4*DIGITS-1:0] w);
    @(negedge clk);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    bcd_input = w;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    bcd_input = 12'($urandom);
  endtask

  // Counts rising edges after the accept edge until out_valid is seen.
  // Returns sampled at a falling edge.
  task automatic wait_valid(output int edges);
    edges = 0;
    @(negedge clk);
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic convert_check(input logic [4*DIGITS-1:0] w);
    logic exp_err;
    int   exp_val;
    int   edges;
    int   stall;
    ref_conv(w, exp_err, exp_val);
    out_ready = 1'b0;
    accept(w);
    wait_valid(edges);
    // Legal words finish on the BIN_WIDTH-th edge after accept; illegal
    // words are already in DONE right after the accept edge.
    chk("latency", 32'(edges), exp_err ? 32'd0 : 32'(BIN_WIDTH));
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("binary_output", 32'(binary_output), 32'(exp_val));
    chk("error", 32'(error), 32'(exp_err));
    chk("in_ready_in_done", 32'(in_ready), 32'd0);
    stall = $urandom_range(0, 2);
    repeat (stall) @(negedge clk);
    chk("held_result", 32'({out_valid, binary_output}), 32'({1'b1, exp_val[BIN_WIDTH-1:0]}));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("out_valid_after_handoff", 32'(out_valid), 32'd0);
    chk("in_ready_after_handoff", 32'(in_ready), 32'd1);
    chk("result_kept_after_handoff", 32'(binary_output), 32'(exp_val));
  endtask

  initial begin
    logic [4*DIGITS-1:0] w;
    logic [BIN_WIDTH-1:0] exp_q[$];
    logic [BIN_WIDTH-1:0] got_q[$];
    int acc_cyc[$];
    logic [4*DIGITS-1:0] words [3];
    int idx;
    int cyc;
    int edges;
    int seen;
    logic took;

    rst       = 1'b1;
    in_valid  = 1'b0;
    bcd_input = '0;
    out_ready = 1'b0;

    // reset state
    #3;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_binary_output", 32'(binary_output), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // basic values
    convert_check(12'h000);
    convert_check(12'h255);
    convert_check(12'h999);

    // invalid digits, then a legal word
    convert_check(12'h1A5);
    convert_check(12'h0F0);
    convert_check(12'h042);

    // output back-pressure with an ignored input pulse
    out_ready = 1'b0;
    accept(12'h128);
    wait_valid(edges);
    chk("bp_latency", 32'(edges), 32'(BIN_WIDTH));
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        in_valid  = 1'b1;
        bcd_input = 12'h777;
      end
      if (i == 6) in_valid = 1'b0;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_binary_output", 32'(binary_output), 32'd128);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_result", 32'(binary_output), 32'd128);

    // back-to-back with in_valid held high
    words[0] = 12'h001;
    words[1] = 12'h500;
    words[2] = 12'h999;
    exp_q = '{10'd1, 10'd500, 10'd999};
    idx = 0;
    cyc = 0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b1;
    bcd_input = words[0];
    while (got_q.size() < 3 && cyc < 100) begin
      if (cyc > 0) @(negedge clk);
      if (out_valid) got_q.push_back(binary_output);
      took = in_ready && in_valid;
      if (took) acc_cyc.push_back(cyc);
      @(posedge clk);
      cyc++;
      #1;
      if (took) begin
        idx++;
        if (idx < 3) bcd_input = words[idx];
        else in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_result_count", 32'(got_q.size()), 32'd3);
    chk("b2b_accept_count", 32'(acc_cyc.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) chk("b2b_result", 32'(got_q[i]), 32'(exp_q[i]));
    end
    if (acc_cyc.size() == 3) begin
      chk("b2b_spacing_01", 32'(acc_cyc[1] - acc_cyc[0]), 32'(BIN_WIDTH + 2));
      chk("b2b_spacing_12", 32'(acc_cyc[2] - acc_cyc[1]), 32'(BIN_WIDTH + 2));
    end

    // reset in the middle of a conversion
    @(negedge clk);
    accept(12'h321);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_binary_output", 32'(binary_output), 32'd0);
    chk("midrst_error", 32'(error), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_output", 32'(seen), 32'd0);
    convert_check(12'h064);

    // sweep of every legal 3-digit word
    for (int v = 0; v < 1000; v++) begin
      w = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      convert_check(w);
    end

    // one random illegal nibble in each digit position
    for (int p = 0; p < DIGITS; p++) begin
      w = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      w[4*p +: 4] = 4'($urandom_range(10, 15));
      convert_check(w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary_converter.md
Name: bcd_to_binary_converter

Overview:
- Sequential BCD-to-binary converter; the reverse direction of the existing binary-to-BCD block.
- Accepts a packed multi-digit BCD word and produces its unsigned binary value using reverse double dabble: one right-shift per clock, then a subtract-3 correction.
- Valid/ready handshake on both input and output, so it sits between a BCD source (keypad or display front-end) and binary datapath logic.
- Flags any non-decimal input digit instead of converting it.

Parameters:
- DIGITS, 3, number of BCD digits in bcd_input.
- BIN_WIDTH, 10, width of binary_output; also the number of conversion iterations. Must satisfy 2^BIN_WIDTH >= 10^DIGITS.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  bcd_input is valid.
- in_ready  output  1  block can accept a new word; high only in IDLE.
- bcd_input  input  4*DIGITS  packed BCD; digit 0 is bits [3:0], the most significant digit is the top nibble.
- out_valid  output  1  binary_output and error are valid.
- out_ready  input  1  downstream accepts the result.
- binary_output  output  BIN_WIDTH  converted value; 0 when error is set.
- error  output  1  captured word contained a digit greater than 9.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, binary_output=0, error=0.
  - Internal shift registers and iteration counter are cleared.
  - A reset mid-conversion or while holding a result discards it; no output is produced for that word.
- States: IDLE, CONVERT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, the word is accepted (edge E0).
  - If any nibble >9: go directly to DONE with error=1 and binary_output=0. out_valid is visible the cycle after E0.
  - Otherwise: load bcd_sr=bcd_input, bin_sr=0, counter=0, and go to CONVERT.
- CONVERT:
  - in_ready=0.
  - Each edge performs one iteration: first shift the concatenation {bcd_sr, bin_sr} right by 1, then for every 4-bit digit of the shifted bcd_sr, subtract 3 if the digit is >=8.
  - Digit corrections are independent and applied in parallel within the same cycle.
  - counter increments each edge.
  - On the BIN_WIDTH-th iteration edge (E_BIN_WIDTH): binary_output is loaded from the final bin_sr, error=0, state goes to DONE.
  - After that edge bcd_sr is all-zero for every legal input.
- DONE:
  - out_valid=1; binary_output and error are held stable.
  - On an edge with out_ready=1: out_valid goes to 0 and state goes to IDLE. binary_output and error keep their last values.
  - in_ready=0 throughout DONE, so a new word cannot be accepted on the same edge as the result handoff. Minimum spacing between accepts is BIN_WIDTH+2 cycles.
  - If out_ready stays low, the result is held indefinitely. Input stalls meanwhile and in_valid is ignored.
- Latency:
  - Legal input: out_valid rises BIN_WIDTH cycles after the accept edge (10 by default).
  - Invalid input: out_valid rises 1 cycle after the accept edge.
- Arithmetic:
  - Unsigned only. The maximum result, 10^DIGITS-1, always fits in BIN_WIDTH bits.
  - No rounding and no saturation required.
- in_valid and bcd_input are sampled only on the accept edge; changes during CONVERT or DONE have no effect.
- Reset wins over all other events when asserted simultaneously with a handshake.

Test Plan:
- Basic values: apply bcd_input 0x000, 0x255, 0x999 with out_ready=1 -> binary_output 0, 255, 999 respectively, error=0, out_valid exactly 10 cycles after each accept.
- Invalid digit: bcd_input 0x1A5 -> out_valid one cycle after accept, error=1, binary_output=0. Then 0x0F0 -> error=1. Then 0x042 -> 42 with error=0.
- Output back-pressure: convert 0x128 with out_ready=0 for 20 cycles -> out_valid held, binary_output=128 stable, in_ready=0, a pulsed in_valid with 0x777 ignored. Raise out_ready -> out_valid drops after one edge, in_ready returns to 1.
- Back-to-back: hold in_valid=1 with words 0x001, 0x500, 0x999 and out_ready=1 -> three results 1, 500, 999 in order, consecutive accepts exactly 12 cycles apart.
- Reset mid-operation: accept 0x321, assert rst asynchronously in CONVERT iteration 5 -> outputs clear immediately, no out_valid. After release, 0x064 converts to 64.
- Exhaustive sweep: all 1000 legal 3-digit inputs vs. a reference model -> zero mismatches, error never set. Also one random illegal nibble per digit position -> error=1.
